// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with single-cycle logic/arith/shift ops, a signed
// radix-2 Booth multiplier and a signed restoring divider (one bit per cycle).
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   start      request, accepted when busy=0
//   op[4:0]    opcode, sampled with start
//   a, b       operands, sampled with start
//   busy       high while an accepted operation is in flight (incl. DONE cycle)
//   done       one-cycle completion pulse
//   result_lo  result low word (held until the next completion)
//   result_hi  result high word (product high half / remainder / 0)
//   div0       divide-by-zero flag, valid with done
//   illegal    undefined-opcode flag, valid with done
module seq_alu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div0,
  output logic             illegal
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

  typedef enum logic [4:0] {
    OP_ADD  = 5'b00011,
    OP_SUB  = 5'b00100,
    OP_SHR  = 5'b00101,
    OP_SHRA = 5'b00110,
    OP_SHL  = 5'b00111,
    OP_ROR  = 5'b01000,
    OP_ROL  = 5'b01001,
    OP_AND  = 5'b01010,
    OP_OR   = 5'b01011,
    OP_MUL  = 5'b01111,
    OP_DIV  = 5'b10000,
    OP_NEG  = 5'b10001,
    OP_NOT  = 5'b10010
  } op_e;

  state_e           state_q, state_d;
  // Shared iteration registers: Booth uses acc/q/qm1/m, divider uses acc
  // (partial remainder), q (dividend shifting into quotient) and m (|b|).
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             qm1_q, qm1_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] result_lo_q, result_lo_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic             div0_q, div0_d;
  logic             illegal_q, illegal_d;

  // Single-cycle datapath
  logic [SHW-1:0]     sh;
  logic [2*WIDTH-1:0] dbl;
  logic [WIDTH-1:0]   alu_lo;
  logic               alu_legal;

  always_comb begin
    sh        = b[SHW-1:0];
    dbl       = '0;
    alu_lo    = '0;
    alu_legal = 1'b1;
    case (op)
      OP_ADD:  alu_lo = a + b;
      OP_SUB:  alu_lo = a - b;
      OP_AND:  alu_lo = a & b;
      OP_OR:   alu_lo = a | b;
      OP_NOT:  alu_lo = ~a;
      OP_NEG:  alu_lo = '0 - b;
      OP_SHR:  alu_lo = a >> sh;
      OP_SHRA: alu_lo = $signed(a) >>> sh;
      OP_SHL:  alu_lo = a << sh;
      // Rotates shift a doubled copy so the wrapped bits fall into the window.
      OP_ROR: begin
        dbl    = {a, a} >> sh;
        alu_lo = dbl[WIDTH-1:0];
      end
      OP_ROL: begin
        dbl    = {a, a} << sh;
        alu_lo = dbl[2*WIDTH-1:WIDTH];
      end
      OP_MUL, OP_DIV: alu_lo = '0;
      default: alu_legal = 1'b0;
    endcase
  end

  // Booth step: add/subtract sign-extended multiplicand into a WIDTH+1 bit
  // accumulator (extra bit absorbs the most-negative case), then arithmetic
  // shift {acc, q, qm1} right by one.
  logic [WIDTH:0]   m_ext, booth_sum, booth_acc_n;
  logic [WIDTH-1:0] booth_q_n;

  always_comb begin
    m_ext = {m_q[WIDTH-1], m_q};
    case ({q_q[0], qm1_q})
      2'b01:   booth_sum = acc_q + m_ext;
      2'b10:   booth_sum = acc_q - m_ext;
      default: booth_sum = acc_q;
    endcase
    booth_acc_n = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    booth_q_n   = {booth_sum[0], q_q[WIDTH-1:1]};
  end

  // Restoring division step on magnitudes.
  logic [WIDTH:0]   div_shift, div_trial, div_rem_n;
  logic [WIDTH-1:0] div_q_n;

  always_comb begin
    div_shift = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, m_q};
    div_rem_n = div_trial[WIDTH] ? div_shift : div_trial;
    div_q_n   = {q_q[WIDTH-2:0], ~div_trial[WIDTH]};
  end

  logic [WIDTH-1:0] a_abs, b_abs;
  assign a_abs = a[WIDTH-1] ? ('0 - a) : a;
  assign b_abs = b[WIDTH-1] ? ('0 - b) : b;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    q_d         = q_q;
    m_d         = m_q;
    qm1_d       = qm1_q;
    cnt_d       = cnt_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    result_lo_d = result_lo_q;
    result_hi_d = result_hi_q;
    div0_d      = div0_q;
    illegal_d   = illegal_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d = '0;
          if (op == OP_MUL) begin
            acc_d   = '0;
            q_d     = b;
            m_d     = a;
            qm1_d   = 1'b0;
            state_d = MUL;
          end else if (op == OP_DIV) begin
            if (b == '0) begin
              result_lo_d = '1;
              result_hi_d = a;
              div0_d      = 1'b1;
              illegal_d   = 1'b0;
              state_d     = DONE;
            end else begin
              acc_d   = '0;
              q_d     = a_abs;
              m_d     = b_abs;
              qneg_d  = a[WIDTH-1] ^ b[WIDTH-1];
              rneg_d  = a[WIDTH-1];
              state_d = DIV;
            end
          end else begin
            result_lo_d = alu_lo;
            result_hi_d = '0;
            div0_d      = 1'b0;
            illegal_d   = ~alu_legal;
            state_d     = DONE;
          end
        end
      end
      MUL: begin
        acc_d = booth_acc_n;
        q_d   = booth_q_n;
        qm1_d = q_q[0];
        cnt_d = cnt_q + 1'b1;
        // WIDTH is a power of two, so all-ones count marks the last iteration.
        if (&cnt_q) begin
          result_lo_d = booth_q_n;
          result_hi_d = booth_acc_n[WIDTH-1:0];
          div0_d      = 1'b0;
          illegal_d   = 1'b0;
          state_d     = DONE;
        end
      end
      DIV: begin
        acc_d = div_rem_n;
        q_d   = div_q_n;
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) begin
          result_lo_d = qneg_q ? ('0 - div_q_n) : div_q_n;
          result_hi_d = rneg_q ? ('0 - div_rem_n[WIDTH-1:0]) : div_rem_n[WIDTH-1:0];
          div0_d      = 1'b0;
          illegal_d   = 1'b0;
          state_d     = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      q_q         <= '0;
      m_q         <= '0;
      qm1_q       <= 1'b0;
      cnt_q       <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      result_lo_q <= '0;
      result_hi_q <= '0;
      div0_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      q_q         <= q_d;
      m_q         <= m_d;
      qm1_q       <= qm1_d;
      cnt_q       <= cnt_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      result_lo_q <= result_lo_d;
      result_hi_q <= result_hi_d;
      div0_q      <= div0_d;
      illegal_q   <= illegal_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign result_lo = result_lo_q;
  assign result_hi = result_hi_q;
  assign div0      = div0_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: scoreboard bench for seq_alu (WIDTH=32). Expected results come
// from a behavioural model using 64-bit arithmetic and bitwise loops.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, div0, illegal;
  logic [31:0] result_lo, result_hi;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result_lo(result_lo), .result_hi(result_hi),
    .div0(div0), .illegal(illegal)
  );

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        d0;
    logic        il;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [4:0] o, input logic [31:0] av, input logic [31:0] bv);
    exp_t   e;
    longint sa, sb_, p, qt, rm;
    int     s;
    e.lo = '0; e.hi = '0; e.d0 = 1'b0; e.il = 1'b0; e.lat = 1;
    sa  = longint'($signed(av));
    sb_ = longint'($signed(bv));
    s   = int'(bv[4:0]);
    case (o)
      5'b00011: e.lo = av + bv;
      5'b00100: e.lo = av - bv;
      5'b01010: e.lo = av & bv;
      5'b01011: e.lo = av | bv;
      5'b10010: e.lo = ~av;
      5'b10001: e.lo = 32'd0 - bv;
      5'b00101: for (int i = 0; i < 32; i++) e.lo[i] = (i + s < 32) ? av[i + s] : 1'b0;
      5'b00110: for (int i = 0; i < 32; i++) e.lo[i] = (i + s < 32) ? av[i + s] : av[31];
      5'b00111: for (int i = 0; i < 32; i++) e.lo[i] = (i >= s) ? av[i - s] : 1'b0;
      5'b01000: for (int i = 0; i < 32; i++) e.lo[i] = av[(i + s) % 32];
      5'b01001: for (int i = 0; i < 32; i++) e.lo[i] = av[(i - s + 32) % 32];
      5'b01111: begin
        p = sa * sb_;
        e.lo = p[31:0]; e.hi = p[63:32]; e.lat = 33;
      end
      5'b10000: begin
        if (bv == 32'd0) begin
          e.lo = 32'hFFFF_FFFF; e.hi = av; e.d0 = 1'b1;
        end else begin
          qt = sa / sb_;
          rm = sa % sb_;
          e.lo = qt[31:0]; e.hi = rm[31:0]; e.lat = 33;
        end
      end
      default: e.il = 1'b1;
    endcase
    return e;
  endfunction

  // Call at a negedge; returns at a negedge one cycle after done.
  task automatic run_op(input logic [4:0] o, input logic [31:0] av, input logic [31:0] bv, input bit poke);
    exp_t e;
    int   cyc;
    sb.push_back(model(o, av, bv));
    start = 1'b1; op = o; a = av; b = bv;
    @(negedge clk);
    cyc = 1;
    check_val("busy_after_accept", 64'(busy), 64'(1));
    // Operands change after accept; an optional extra start must be ignored.
    start = poke; op = 5'b10000; a = $urandom; b = $urandom;
    while (done !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    e = sb.pop_front();
    check_val("done_seen", 64'(done), 64'(1));
    check_val("latency", 64'(cyc), 64'(e.lat));
    check_val("result_lo", 64'(result_lo), 64'(e.lo));
    check_val("result_hi", 64'(result_hi), 64'(e.hi));
    check_val("div0", 64'(div0), 64'(e.d0));
    check_val("illegal", 64'(illegal), 64'(e.il));
    @(negedge clk);
    check_val("idle_after_done", 64'({busy, done}), 64'(0));
  endtask

  logic [4:0]  ops [15] = '{5'b00011, 5'b00100, 5'b01010, 5'b01011, 5'b10010,
                            5'b10001, 5'b00101, 5'b00110, 5'b00111, 5'b01000,
                            5'b01001, 5'b01111, 5'b10000, 5'b11111, 5'b00000};
  logic [31:0] specials [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000,
                                32'h7FFF_FFFF, 32'h5};

  function automatic logic [31:0] pick();
    if ($urandom_range(0, 2) == 0) return specials[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    int ndone;
    #1;
    check_val("reset_outputs", 64'({busy, done, div0, illegal}), 64'(0));
    check_val("reset_lo_hi", {result_hi, result_lo}, 64'(0));
    repeat (3) @(negedge clk);
    reset = 1'b0;
    // First start goes in the same timestep reset is released.
    run_op(5'b00011, 32'h7FFF_FFFF, 32'h1, 1'b0);
    run_op(5'b01111, 32'hFFFF_FFFD, 32'h7, 1'b1);
    run_op(5'b10000, 32'hFFFF_FFF9, 32'h2, 1'b0);
    run_op(5'b10000, 32'hFFFF_FFF9, 32'h0, 1'b0);
    run_op(5'b01000, 32'h8000_0001, 32'h1, 1'b0);
    run_op(5'b00110, 32'h8000_0000, 32'd36, 1'b1);
    run_op(5'b01001, 32'h8000_0001, 32'h0, 1'b0);
    run_op(5'b11111, 32'h1234_5678, 32'h9, 1'b0);
    run_op(5'b10001, 32'h0, 32'h8000_0000, 1'b0);
    run_op(5'b10000, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(5'b10000, 32'h7, 32'hFFFF_FFFE, 1'b0);
    run_op(5'b01111, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op(5'b00100, 32'h0, 32'h1, 1'b0);
    run_op(5'b00101, 32'h8000_0000, 32'd31, 1'b0);
    run_op(5'b00111, 32'hFFFF_FFFF, 32'd33, 1'b0);
    for (int n = 0; n < 30; n++)
      run_op(ops[$urandom_range(0, 14)], pick(), pick(), 1'($urandom_range(0, 1)));

    // Leave non-zero results/flags behind, then reset in the middle of a MUL.
    run_op(5'b10000, 32'hDEAD_BEEF, 32'h0, 1'b0);
    start = 1'b1; op = 5'b01111; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1; start = 1'b1; op = 5'b00011;
    #1;
    check_val("rst_busy_done", 64'({busy, done}), 64'(0));
    check_val("rst_flags", 64'({div0, illegal}), 64'(0));
    check_val("rst_result_lo", 64'(result_lo), 64'(0));
    check_val("rst_result_hi", 64'(result_hi), 64'(0));
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    check_val("no_done_after_rst", 64'(ndone), 64'(0));
    check_val("idle_after_rst", 64'(busy), 64'(0));
    run_op(5'b00011, 32'h0000_00FF, 32'h0000_0001, 1'b1);
    run_op(5'b01111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
